vmem_fill_arb: RTL and testbench

- Hardware rectangle-fill engine for the 32x128 text video memory (12-bit address {row[4:0], col[6:0]}, 16-bit cell = {bspecial, bspec[2:0], fspecial, fspec[2:0], ascii[7:0]}).
- Owns the single vmem write port and arbitrates it between CPU stores (dmem tag "vga") and the fill engine.
- The CPU programs the engine through a small MMIO register window (new dmem tag "vga_fill"). It sits between the CPU's dmem write path and the vmem wraddress/data/wren pins, clocked by dmemwrclk.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vmem_fill_arb_if.sv | 25 ++
 rtl/vmem_fill_arb_rect_addr_gen.sv | 37 +++
 rtl/vmem_fill_arb.sv | 133 +++++++++++++
 tb/tb_vmem_fill_arb.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the text video-memory fill engine.
package vga_pkg;

  localparam int unsigned VMEM_AW = 12;
  localparam int unsigned VMEM_DW = 16;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COL_W   = 7;

  localparam logic [1:0] CFG_START = 2'd0;
  localparam logic [1:0] CFG_END   = 2'd1;
  localparam logic [1:0] CFG_FILL  = 2'd2;
  localparam logic [1:0] CFG_CTRL  = 2'd3;

  localparam int unsigned CTRL_GO      = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_CLR_ERR = 2;

  localparam logic [3:0] TAG_VGA_FILL = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

endpackage

// File: rtl/vmem_fill_arb_if.sv
// CPU store/config side and vmem write side of the fill arbiter.
interface vmem_fill_arb_if;
  import vga_pkg::*;

  logic               cpu_we;
  logic [VMEM_AW-1:0] cpu_addr;
  logic [VMEM_DW-1:0] cpu_data;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [31:0]        cfg_data;
  logic               vm_wren;
  logic [VMEM_AW-1:0] vm_wraddr;
  logic [VMEM_DW-1:0] vm_data;
  logic [31:0]        status;

  modport master (
    output cpu_we, cpu_addr, cpu_data, cfg_we, cfg_sel, cfg_data,
    input  vm_wren, vm_wraddr, vm_data, status
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, cfg_we, cfg_sel, cfg_data,
    output vm_wren, vm_wraddr, vm_data, status
  );
endinterface

// File: rtl/vmem_fill_arb_rect_addr_gen.sv
// Row/column walker over a rectangle: row-major order, column wraps to start column.
module rect_addr_gen
  import vga_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [ROW_W-1:0] start_row,
  input  logic [COL_W-1:0] start_col,
  input  logic [ROW_W-1:0] end_row,
  input  logic [COL_W-1:0] end_col,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  always_ff @(posedge clock) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= start_row;
      col <= start_col;
    end else if (advance) begin
      if (col == end_col) begin
        col <= start_col;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == end_row) && (col == end_col);

endmodule

// File: rtl/vmem_fill_arb.sv
// vmem write-port owner: CPU stores take strict priority over the rectangle fill engine.
module vmem_fill_arb
  import vga_pkg::*;
#(
  parameter int unsigned ROWS = 30,
  parameter int unsigned COLS = 80
) (
  input  logic           clock,
  input  logic           reset,
  vmem_fill_arb_if.slave bus
);

  fill_state_t        state, state_next;
  logic [ROW_W-1:0]   start_row, end_row, cur_row;
  logic [COL_W-1:0]   start_col, end_col, cur_col;
  logic [VMEM_DW-1:0] fill_word;
  logic               err, err_next, done_sticky;
  logic               busy, cur_last, rect_ok;
  logic               ctrl_wr, go, abort, clr_err;
  logic               start_fill, advance;
  logic [10:0]        cfg_data_unused;

  assign cfg_data_unused = bus.cfg_data[31:21];

  assign busy    = (state != IDLE);
  assign ctrl_wr = bus.cfg_we && (bus.cfg_sel == CFG_CTRL);
  assign go      = ctrl_wr && bus.cfg_data[CTRL_GO];
  assign abort   = ctrl_wr && bus.cfg_data[CTRL_ABORT];
  assign clr_err = ctrl_wr && bus.cfg_data[CTRL_CLR_ERR];

  assign rect_ok = (start_row <= end_row) && (start_col <= end_col) &&
                   (32'(end_row) < ROWS) && (32'(end_col) < COLS);

  // Abort suppresses go entirely, whether idle or busy.
  assign start_fill = go && !abort && (state == IDLE) && rect_ok;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_fill) state_next = FILL;
      FILL: begin
        if (abort)                    state_next = IDLE;
        else if (advance && cur_last) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    advance = (state == FILL) && !bus.cpu_we && !abort;
  end

  rect_addr_gen u_addr (
    .clock     (clock),
    .reset     (reset),
    .load      (start_fill),
    .advance   (advance),
    .start_row (start_row),
    .start_col (start_col),
    .end_row   (end_row),
    .end_col   (end_col),
    .row       (cur_row),
    .col       (cur_col),
    .last      (cur_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      start_row <= '0;
      start_col <= '0;
      end_row   <= '0;
      end_col   <= '0;
      fill_word <= '0;
    end else if (bus.cfg_we && (state == IDLE)) begin
      unique case (bus.cfg_sel)
        CFG_START: begin
          start_row <= bus.cfg_data[20:16];
          start_col <= bus.cfg_data[6:0];
        end
        CFG_END: begin
          end_row <= bus.cfg_data[20:16];
          end_col <= bus.cfg_data[6:0];
        end
        CFG_FILL: fill_word <= bus.cfg_data[15:0];
        default: ;
      endcase
    end
  end

  // Clear is applied before go is judged, so clear+go can re-raise err.
  always_comb begin
    err_next = err;
    if (clr_err) err_next = 1'b0;
    if (go && !abort && (busy || !rect_ok)) err_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err         <= 1'b0;
      done_sticky <= 1'b0;
    end else begin
      err <= err_next;
      if (start_fill)         done_sticky <= 1'b0;
      else if (state == DONE) done_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.vm_wren   <= 1'b0;
      bus.vm_wraddr <= '0;
      bus.vm_data   <= '0;
    end else begin
      bus.vm_wren <= bus.cpu_we || advance;
      if (bus.cpu_we) begin
        bus.vm_wraddr <= bus.cpu_addr;
        bus.vm_data   <= bus.cpu_data;
      end else if (advance) begin
        bus.vm_wraddr <= {cur_row, cur_col};
        bus.vm_data   <= fill_word;
      end
    end
  end

  assign bus.status = {29'd0, done_sticky, err, busy};

endmodule

// File: tb/tb_vmem_fill_arb.sv
// Directed bench for vmem_fill_arb with an ordered write scoreboard.
module tb_vmem_fill_arb;
  import vga_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  vmem_fill_arb_if bus ();

  vmem_fill_arb #(.ROWS(30), .COLS(80)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int busy_cnt = 0;
  int base;
  logic [11:0] last_addr = '0;
  logic [27:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [27:0] e;
    @(posedge clock);
    #1;
    if (bus.status[0] === 1'b1) busy_cnt++;
    if (bus.vm_wren === 1'b1) begin
      wr_count++;
      last_addr = bus.vm_wraddr;
      if (exp_q.size() == 0) begin
        chk("spurious_write", {31'd0, bus.vm_wren}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {20'd0, bus.vm_wraddr}, {20'd0, e[27:16]});
        chk("wr_data", {16'd0, bus.vm_data}, {16'd0, e[15:0]});
      end
    end
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input logic [31:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_data = d;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic push_rect(input int sr, input int sc, input int er, input int ec,
                           input logic [15:0] d, input int max_n);
    int n = 0;
    for (int r = sr; r <= er; r++)
      for (int c = sc; c <= ec; c++)
        if (n < max_n) begin
          exp_q.push_back({5'(r), 7'(c), d});
          n++;
        end
  endtask

  task automatic wait_idle(input int limit);
    int g = 0;
    while (bus.status[0] === 1'b1 && g < limit) begin
      tick();
      g++;
    end
    chk("idle_timeout", {31'd0, bus.status[0]}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_data = '0;
    tick(); tick();
    chk("rst_status", bus.status, 32'd0);
    chk("rst_wren", {31'd0, bus.vm_wren}, 32'd0);
    chk("rst_addr", {20'd0, bus.vm_wraddr}, 32'd0);
    chk("rst_data", {16'd0, bus.vm_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic 2x3 fill
    cfg_wr(CFG_START, 32'h0002_0005);
    cfg_wr(CFG_END,   32'h0003_0007);
    cfg_wr(CFG_FILL,  32'h0000_0F41);
    push_rect(2, 5, 3, 7, 16'h0F41, 100);
    base = wr_count; busy_cnt = 0;
    cfg_wr(CFG_CTRL, 32'd1);
    wait_idle(50);
    chk("t1_busy_cycles", busy_cnt, 32'd7);
    chk("t1_writes", wr_count - base, 32'd6);
    chk("t1_status", bus.status, 32'b100);
    chk("t1_queue", exp_q.size(), 32'd0);

    // Same fill with CPU stores in cycles 2 and 3
    exp_q.push_back({5'd2, 7'd5, 16'h0F41});
    exp_q.push_back({12'h000, 16'h1234});
    exp_q.push_back({12'h000, 16'h1234});
    push_rect(2, 6, 2, 7, 16'h0F41, 100);
    push_rect(3, 5, 3, 7, 16'h0F41, 100);
    base = wr_count; busy_cnt = 0;
    cfg_wr(CFG_CTRL, 32'd1);
    tick();
    bus.cpu_we = 1'b1; bus.cpu_addr = 12'h000; bus.cpu_data = 16'h1234;
    tick(); tick();
    bus.cpu_we = 1'b0;
    wait_idle(50);
    chk("t2_busy_cycles", busy_cnt, 32'd9);
    chk("t2_writes", wr_count - base, 32'd8);
    chk("t2_queue", exp_q.size(), 32'd0);

    // Validation errors and clear
    base = wr_count;
    cfg_wr(CFG_END, 32'h001E_0000);
    cfg_wr(CFG_CTRL, 32'd1);
    tick(); tick();
    chk("t3_row_err", bus.status, 32'b110);
    cfg_wr(CFG_CTRL, 32'd4);
    chk("t3_clear", bus.status, 32'b100);
    cfg_wr(CFG_END, 32'h0003_0004);
    cfg_wr(CFG_CTRL, 32'd1);
    chk("t3_col_err", bus.status, 32'b110);
    cfg_wr(CFG_CTRL, 32'd5);
    chk("t3_clr_go_err", bus.status, 32'b110);
    cfg_wr(CFG_CTRL, 32'd4);
    chk("t3_clear2", bus.status, 32'b100);
    cfg_wr(CFG_END, 32'h0003_0007);
    busy_cnt = 0;
    cfg_wr(CFG_CTRL, 32'd3);
    tick(); tick();
    chk("t3_go_abort_status", bus.status, 32'b100);
    chk("t3_go_abort_busy", busy_cnt, 32'd0);
    chk("t3_no_writes", wr_count - base, 32'd0);

    // Full screen
    cfg_wr(CFG_START, 32'h0000_0000);
    cfg_wr(CFG_END,   32'h001D_004F);
    cfg_wr(CFG_FILL,  32'h0000_0720);
    push_rect(0, 0, 29, 79, 16'h0720, 3000);
    base = wr_count; busy_cnt = 0;
    cfg_wr(CFG_CTRL, 32'd1);
    wait_idle(3000);
    chk("t4_busy_cycles", busy_cnt, 32'd2401);
    chk("t4_writes", wr_count - base, 32'd2400);
    chk("t4_last_addr", {20'd0, last_addr}, 32'h0ECF);
    chk("t4_queue", exp_q.size(), 32'd0);
    chk("t4_status", bus.status, 32'b100);

    // Abort after three writes; FILL write and go while busy
    cfg_wr(CFG_START, 32'h0001_0000);
    cfg_wr(CFG_END,   32'h0001_0009);
    cfg_wr(CFG_FILL,  32'h0000_AAAA);
    push_rect(1, 0, 1, 9, 16'hAAAA, 3);
    base = wr_count;
    cfg_wr(CFG_CTRL, 32'd1);
    cfg_wr(CFG_FILL, 32'h0000_5555);
    cfg_wr(CFG_CTRL, 32'd1);
    tick();
    chk("t5_writes_before_abort", wr_count - base, 32'd3);
    chk("t5_busy_err", bus.status, 32'b011);
    cfg_wr(CFG_CTRL, 32'd2);
    chk("t5_wren_after_abort", {31'd0, bus.vm_wren}, 32'd0);
    tick(); tick(); tick();
    chk("t5_writes_total", wr_count - base, 32'd3);
    chk("t5_status", bus.status, 32'b010);
    chk("t5_queue", exp_q.size(), 32'd0);
    cfg_wr(CFG_CTRL, 32'd4);
    chk("t5_clear", bus.status, 32'd0);

    // Reset mid-fill, then single-cell fill from reset registers
    cfg_wr(CFG_START, 32'h0004_000A);
    cfg_wr(CFG_END,   32'h0004_0013);
    cfg_wr(CFG_FILL,  32'h0000_1111);
    push_rect(4, 10, 4, 19, 16'h1111, 3);
    base = wr_count;
    cfg_wr(CFG_CTRL, 32'd1);
    tick(); tick(); tick();
    chk("t6_writes_before_reset", wr_count - base, 32'd3);
    reset = 1'b1;
    tick();
    chk("t6_wren", {31'd0, bus.vm_wren}, 32'd0);
    chk("t6_status", bus.status, 32'd0);
    chk("t6_addr", {20'd0, bus.vm_wraddr}, 32'd0);
    chk("t6_data", {16'd0, bus.vm_data}, 32'd0);
    reset = 1'b0;
    tick();
    exp_q.push_back({12'h000, 16'h0000});
    base = wr_count; busy_cnt = 0;
    cfg_wr(CFG_CTRL, 32'd1);
    wait_idle(20);
    chk("t6_single_busy", busy_cnt, 32'd2);
    chk("t6_single_writes", wr_count - base, 32'd1);
    chk("t6_single_status", bus.status, 32'b100);
    chk("t6_queue", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
